lcd_12864b_bus_drv: RTL and testbench
=====================================

Name: lcd_12864b_bus_drv

Overview:
- Low-level write engine for the ST7920 128x64 LCD in 8-bit parallel mode.
- Sits directly downstream of the init/text sequencer in lcd_12864b_top and drives the rs/rw/e/data pins.
- Accepts one byte plus register select per valid/ready handshake.
- Generates the setup, E-pulse, hold and controller-execution timing, including the power-up delay after reset.

Parameters:
- PWRUP_CYC, 2000000, cycles to wait after reset before the first transfer (40 ms at 50 MHz).
- SETUP_CYC, 8, cycles rs/data are stable with e=0 before e rises (tAS).
- E_HIGH_CYC, 23, cycles e is held high (PW_EH).
- HOLD_CYC, 4, cycles rs/data stay stable after e falls (tH).
- EXEC_CYC, 3600, execution wait for normal instructions and data writes (72 us).
- CLEAR_CYC, 80000, execution wait for clear (0x01) and return-home (0x02/0x03) commands (1.6 ms).
- All parameters must be >= 1.

Ports:
- osc  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  upstream has a byte to send
- cmd_ready  out  1  block can accept a byte this cycle
- cmd_rs  in  1  0 = instruction, 1 = data
- cmd_data  in  8  byte to write
- busy  out  1  transfer or power-up wait in progress
- rs  out  1  LCD register select
- rw  out  1  LCD read/write, tied to write (0)
- e  out  1  LCD enable strobe
- data  out  8  LCD data bus

Behaviour:
- Reset: one clock (osc); reset is synchronous and active-low (rst_n).
  - While rst_n=0 at a rising edge: state=PWRUP, counter=PWRUP_CYC-1, rs=0, rw=0, e=0, data=8'h00, cmd_ready=0, busy=1.
- States: PWRUP, IDLE, SETUP, E_HIGH, HOLD, EXEC.
- Single down-counter.
  - Loaded with N-1 on state entry; the state exits when the counter is 0.
  - Each timed state therefore lasts exactly N cycles.
  - Width is $clog2(max(PWRUP_CYC, CLEAR_CYC)).
- PWRUP: counts PWRUP_CYC cycles, then goes to IDLE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid & cmd_ready: register cmd_rs->rs and cmd_data->data, latch is_long, enter SETUP.
  - is_long = (cmd_rs==0) && (cmd_data inside {8'h01, 8'h02, 8'h03}).
- SETUP: e=0 for SETUP_CYC cycles, then E_HIGH.
- E_HIGH: e=1 for E_HIGH_CYC cycles, then HOLD.
- HOLD: e=0 for HOLD_CYC cycles, then EXEC.
- EXEC: e=0; waits CLEAR_CYC if is_long, otherwise EXEC_CYC; then IDLE.
- cmd_ready is high only in IDLE. busy equals !cmd_ready.
- Data and rs stability:
  - rs/data change only on handshake acceptance.
  - They hold their value through SETUP/E_HIGH/HOLD/EXEC and after return to IDLE, until the next accept.
  - The byte is therefore valid on the falling edge of e.
- Accept-to-next-ready latency: SETUP_CYC + E_HIGH_CYC + HOLD_CYC + (is_long ? CLEAR_CYC : EXEC_CYC) cycles.
- Back-to-back transfers: the next handshake may occur on the first IDLE cycle; there are no idle gaps beyond that.
- cmd_valid while not ready: ignored. No latching, no queueing, and no effect on outputs.
- Upstream must hold cmd_valid/cmd_rs/cmd_data until ready.
- Reset mid-transfer: outputs take reset values on the next edge; the in-flight byte is dropped and PWRUP restarts.
- e is a registered output, glitch-free, and only ever high in E_HIGH.
- rw is constant 0 in all states.

Decomposition:
- Package lcd_12864b_pkg:
  - state enum.
  - Command constants: CMD_CLEAR=8'h01, CMD_HOME=8'h02, CMD_FUNC_BASIC=8'h30, CMD_DISP_ON_CUR_BLINK=8'h0F, CMD_ENTRY_INC=8'h06.
  - DDRAM line addresses: LINE0=8'h80, LINE1=8'h90, LINE2=8'h88, LINE3=8'h98.
  - Helper function is_long_cmd(rs, data).
- lcd_12864b_top's sequencer imports the same package.
- One natural sub-module: lcd_delay_cnt.
  - Loadable down-counter, parameterised width.
  - Inputs load/value; output zero.
  - Reused by the sequencer for inter-frame delays.

Test Plan (PWRUP_CYC=20, SETUP_CYC=2, E_HIGH_CYC=3, HOLD_CYC=2, EXEC_CYC=10, CLEAR_CYC=50):
1. Release rst_n and hold cmd_valid=0 -> cmd_ready rises exactly 20 cycles after the first edge with rst_n=1; e/rs/data/rw stay 0 throughout.
2. Single data write rs=1, 0x41:
   - e high exactly 3 cycles, beginning 2 cycles after accept.
   - rs=1 and data=0x41 at negedge e; rw=0.
   - cmd_ready returns 17 cycles after accept.
3. Instruction 0x01 with rs=0 -> same strobe shape; cmd_ready returns 57 cycles after accept. Repeat with rs=1, 0x01 -> 17 cycles (data, not long).
4. Streamed sequence 0x30, 0x0F, 0x30, 0x01, 0x06, 0x80, then bytes 0x00..0x0F with cmd_valid held high:
   - negedge-e monitor sees exactly those 22 bytes in order, with no duplicates or drops.
   - Each handshake occurs on the first IDLE cycle.
5. Pulse cmd_valid with 0x55 during E_HIGH of a 0x41 transfer -> ignored; data stays 0x41; no extra e pulse.
6. Assert rst_n=0 during E_HIGH:
   - next edge: e=0, data=0, cmd_ready=0.
   - After release: 20-cycle PWRUP, then a fresh transfer works normally. Bench masks compares while rst_n=0.

Source files
------------

// File: rtl/lcd_12864b_pkg.sv
// Shared types, command constants and helpers for the ST7920 12864B LCD path.
package lcd_12864b_pkg;

  // Bus driver states.
  typedef enum logic [2:0] {
    ST_PWRUP  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_E_HIGH = 3'd3,
    ST_HOLD   = 3'd4,
    ST_EXEC   = 3'd5
  } lcd_state_e;

  // Basic instruction-set commands.
  localparam logic [7:0] CMD_CLEAR             = 8'h01;
  localparam logic [7:0] CMD_HOME              = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT          = 8'h03;  // return-home ignores bit 0
  localparam logic [7:0] CMD_FUNC_BASIC        = 8'h30;
  localparam logic [7:0] CMD_DISP_ON_CUR_BLINK = 8'h0F;
  localparam logic [7:0] CMD_ENTRY_INC         = 8'h06;

  // DDRAM start addresses of the four text lines (set-address commands).
  localparam logic [7:0] LINE0 = 8'h80;
  localparam logic [7:0] LINE1 = 8'h90;
  localparam logic [7:0] LINE2 = 8'h88;
  localparam logic [7:0] LINE3 = 8'h98;

  // Clear and return-home need the long execution wait; everything else is short.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == CMD_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter that saturates at zero; zero flags expiry.
module lcd_delay_cnt #(
  parameter int unsigned     W       = 8,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         osc,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over counting; the count parks at zero until reloaded.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register, restarting from RST_VAL on reset.
  always_ff @(posedge osc) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_12864b_bus_drv.sv
// ST7920 8-bit parallel write engine: one byte per handshake, with setup,
// E strobe, hold and controller execution timing plus the power-up wait.
module lcd_12864b_bus_drv
  import lcd_12864b_pkg::*;
#(
  parameter int unsigned PWRUP_CYC  = 2000000,
  parameter int unsigned SETUP_CYC  = 8,
  parameter int unsigned E_HIGH_CYC = 23,
  parameter int unsigned HOLD_CYC   = 4,
  parameter int unsigned EXEC_CYC   = 3600,
  parameter int unsigned CLEAR_CYC  = 80000
) (
  input  logic       osc,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       rs,
  output logic       rw,
  output logic       e,
  output logic [7:0] data
);

  localparam int unsigned MAX_CYC = (PWRUP_CYC > CLEAR_CYC) ? PWRUP_CYC : CLEAR_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Reload values: a state loaded with N-1 lasts exactly N cycles.
  localparam logic [CNT_W-1:0] LD_PWRUP  = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_E_HIGH = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC   = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR  = CNT_W'(CLEAR_CYC - 1);

  lcd_state_e       state_q, state_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             is_long_q, is_long_d;
  logic             e_q, e_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;

  // Single shared timer; its reset value starts the power-up wait.
  lcd_delay_cnt #(
    .W       (CNT_W),
    .RST_VAL (LD_PWRUP)
  ) u_delay (
    .osc   (osc),
    .rst_n (rst_n),
    .load  (cnt_load),
    .value (cnt_value),
    .zero  (cnt_zero)
  );

  // Next-state logic: advance when the timer expires, reload it on each entry.
  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    data_d    = data_q;
    is_long_d = is_long_q;
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state_q)
      ST_PWRUP: begin
        if (cnt_zero) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d   = ST_SETUP;
          rs_d      = cmd_rs;
          data_d    = cmd_data;
          is_long_d = is_long_cmd(cmd_rs, cmd_data);
          cnt_load  = 1'b1;
          cnt_value = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d   = ST_E_HIGH;
          cnt_load  = 1'b1;
          cnt_value = LD_E_HIGH;
        end
      end
      ST_E_HIGH: begin
        if (cnt_zero) begin
          state_d   = ST_HOLD;
          cnt_load  = 1'b1;
          cnt_value = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d   = ST_EXEC;
          cnt_load  = 1'b1;
          cnt_value = is_long_q ? LD_CLEAR : LD_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_zero) state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_PWRUP;
        cnt_load  = 1'b1;
        cnt_value = LD_PWRUP;
      end
    endcase
    // Outputs are decoded from the next state so they register glitch-free.
    e_d     = (state_d == ST_E_HIGH);
    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
  end

  // State and registered outputs.
  always_ff @(posedge osc) begin
    if (!rst_n) begin
      state_q   <= ST_PWRUP;
      rs_q      <= 1'b0;
      data_q    <= 8'h00;
      is_long_q <= 1'b0;
      e_q       <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      rs_q      <= rs_d;
      data_q    <= data_d;
      is_long_q <= is_long_d;
      e_q       <= e_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign rs        = rs_q;
  assign rw        = 1'b0;
  assign e         = e_q;
  assign data      = data_q;

endmodule

// File: tb/tb_lcd_12864b_bus_drv.sv
// Bench for lcd_12864b_bus_drv with shortened timing parameters.
module tb_lcd_12864b_bus_drv;

  localparam int PWRUP = 20;
  localparam int SETUP = 2;
  localparam int EH    = 3;
  localparam int HOLD  = 2;
  localparam int EXEC  = 10;
  localparam int CLEAR = 50;

  logic       osc = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, busy, rs, rw, e;
  logic [7:0] data;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] sb_q[$];
  logic [8:0] sb_exp;
  logic       mon_mask = 1'b1;
  logic       e_prev = 1'b0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         lat;
  } vec_t;

  vec_t tbl[6];
  vec_t strm[22];

  always #5 osc = ~osc;

  lcd_12864b_bus_drv #(
    .PWRUP_CYC  (PWRUP),
    .SETUP_CYC  (SETUP),
    .E_HIGH_CYC (EH),
    .HOLD_CYC   (HOLD),
    .EXEC_CYC   (EXEC),
    .CLEAR_CYC  (CLEAR)
  ) dut (
    .osc       (osc),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rs    (cmd_rs),
    .cmd_data  (cmd_data),
    .busy      (busy),
    .rs        (rs),
    .rw        (rw),
    .e         (e),
    .data      (data)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(negedge osc);
  endtask

  // Strobe monitor: on every falling edge of e, the byte on the bus must be
  // the next one the scoreboard expects.
  always @(negedge osc) begin
    if (mon_mask) begin
      e_prev = 1'b0;
    end else begin
      if (e_prev && !e) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_e_pulse: got rs=%0d data=0x%0h with nothing queued", rs, data);
        end else begin
          sb_exp = sb_q.pop_front();
          chk("strobe_byte", {23'd0, rs, data}, {23'd0, sb_exp});
          chk("strobe_rw", {31'd0, rw}, 32'd0);
        end
      end
      e_prev = e;
    end
  end

  // Release reset and measure the power-up wait; outputs must stay quiet.
  task automatic pwrup_check(input string tag);
    int k;
    bit quiet;
    k = 0;
    quiet = 1'b1;
    rst_n = 1'b1;
    mon_mask = 1'b0;
    while (!cmd_ready && k < 100) begin
      tick();
      k++;
      if (e || rs || rw || (data != 8'h00)) quiet = 1'b0;
    end
    chk({tag, "_len"}, k, PWRUP);
    chk({tag, "_quiet"}, {31'd0, quiet}, 32'd1);
  endtask

  // One transfer: handshake, then measure strobe position/width and latency.
  task automatic send(input logic r, input logic [7:0] d, input int exp_lat,
                      input bit stream, input bit inject, input string tag);
    int wait_cyc, k, first_e, e_cnt;
    wait_cyc = 0;
    while (!cmd_ready && wait_cyc < 300) begin
      tick();
      wait_cyc++;
    end
    if (stream) chk({tag, "_gap"}, wait_cyc, 0);
    cmd_valid = 1'b1;
    cmd_rs    = r;
    cmd_data  = d;
    sb_q.push_back({r, d});
    tick();
    if (!stream) cmd_valid = 1'b0;
    chk({tag, "_busy"}, {30'd0, cmd_ready, busy}, 32'd1);
    k = 0;
    first_e = -1;
    e_cnt = 0;
    while (!cmd_ready && k < 300) begin
      if (inject && first_e >= 0 && k == first_e + 1) begin
        cmd_valid = 1'b0;
        cmd_rs    = r;
        cmd_data  = d;
      end
      if (e) begin
        if (first_e < 0) begin
          first_e = k;
          if (inject) begin
            cmd_valid = 1'b1;
            cmd_rs    = 1'b0;
            cmd_data  = 8'h55;
          end
        end
        e_cnt++;
      end
      tick();
      k++;
    end
    chk({tag, "_latency"}, k, exp_lat);
    chk({tag, "_e_start"}, first_e, SETUP);
    chk({tag, "_e_width"}, e_cnt, EH);
    chk({tag, "_bus_hold"}, {23'd0, rs, data}, {23'd0, r, d});
    $display("xfer %s rs=%0d data=0x%02h latency=%0d e_start=%0d e_width=%0d",
             tag, r, d, k, first_e, e_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;

    tbl[0] = '{1'b1, 8'h41, 17};
    tbl[1] = '{1'b0, 8'h01, 57};
    tbl[2] = '{1'b1, 8'h01, 17};
    tbl[3] = '{1'b0, 8'h02, 57};
    tbl[4] = '{1'b0, 8'h03, 57};
    tbl[5] = '{1'b0, 8'h04, 17};

    strm[0] = '{1'b0, 8'h30, 17};
    strm[1] = '{1'b0, 8'h0F, 17};
    strm[2] = '{1'b0, 8'h30, 17};
    strm[3] = '{1'b0, 8'h01, 57};
    strm[4] = '{1'b0, 8'h06, 17};
    strm[5] = '{1'b0, 8'h80, 17};
    for (int i = 0; i < 16; i++) strm[6 + i] = '{1'b1, 8'(i), 17};

    // Reset state.
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {19'd0, cmd_ready, busy, e, rs, rw, data},
        {19'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

    pwrup_check("pwrup");

    // Single transfers from the vector table.
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].rs, tbl[i].data, tbl[i].lat, 1'b0, 1'b0, $sformatf("vec%0d", i));
    end

    // Streamed sequence with cmd_valid held high throughout.
    for (int i = 0; i < 22; i++) begin
      send(strm[i].rs, strm[i].data, strm[i].lat, 1'b1, 1'b0, $sformatf("strm%0d", i));
    end
    cmd_valid = 1'b0;
    chk("strm_all_strobed", sb_q.size(), 0);

    // Request pulsed during E high must be ignored.
    send(1'b1, 8'h41, 17, 1'b0, 1'b1, "inject");
    repeat (5) tick();
    chk("inject_no_extra", {31'd0, e}, 32'd0);
    chk("inject_bus_kept", {23'd0, rs, data}, {23'd0, 1'b1, 8'h41});

    // Reset asserted during E high drops the byte and restarts power-up.
    cmd_valid = 1'b1;
    cmd_rs    = 1'b0;
    cmd_data  = 8'h30;
    tick();
    cmd_valid = 1'b0;
    k = 0;
    while (!e && k < 20) begin
      tick();
      k++;
    end
    chk("midrst_reached_e", {31'd0, e}, 32'd1);
    mon_mask = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("midrst_outputs", {21'd0, e, cmd_ready, busy, data}, {21'd0, 1'b0, 1'b0, 1'b1, 8'h00});
    sb_q.delete();
    pwrup_check("pwrup2");
    send(1'b0, 8'h06, 17, 1'b0, 1'b0, "after_rst");
    repeat (3) tick();
    chk("final_queue_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
